spio_link_speed_doubler: RTL and testbench
==========================================

# spio_link_speed_doubler

- Carries rdy/vld packets from a source clocked at half the speed of `CLK_IN` to a sink clocked at full `CLK_IN` speed.
- It is the receive-side counterpart of the link speed halver and sits between a half-rate link front end and full-rate fabric logic.
- The block has a single clock domain. The slow side is represented only by a phase strobe, and a 2-entry buffer gives full slow-side throughput.

## Interface
Parameters:
- `PKT_BITS`, 72, packet width in bits.

Ports:
- `CLK_IN` in 1: fast clock. All logic is on its rising edge.
- `RESET_N_IN` in 1: one clock; reset is synchronous and active-low.
- `PHASE_IN` in 1: high in the last fast cycle of each slow period. The slow-clock edge falls at the end of this cycle.
- `DATA_IN` in `PKT_BITS`: slow-side data. It is stable across each slow period.
- `VLD_IN` in 1: slow-side valid. It is stable across each slow period.
- `RDY_OUT` out 1: slow-side ready. It changes only at the end of `PHASE_IN` cycles.
- `DATA_OUT` out `PKT_BITS`: fast-side data, equal to the buffer head.
- `VLD_OUT` out 1: fast-side valid. It is high when the buffer is non-empty.
- `RDY_IN` in 1: fast-side ready.
- `PHASE_ERR_OUT` out 1: sticky flag, set when `PHASE_IN` is high in two consecutive cycles.

## Operation
- Input transfer (push): occurs at the end of any cycle where `PHASE_IN && VLD_IN && RDY_OUT`.
  - `VLD_IN` and `RDY_OUT` in non-phase cycles are ignored.
- Output transfer (pop): occurs at the end of any cycle where `VLD_OUT && RDY_IN`.
- Buffer: 2 entries, FIFO order, with a 2-bit `count` (0..2).
  - `count_next = count + push - pop`.
  - Push and pop in the same cycle leave `count` unchanged and advance the head.
- `RDY_OUT` register:
  - Updated only when `PHASE_IN` is high: `RDY_OUT <= (count_next <= 1)`.
  - Otherwise it holds its value.
  - Between phase cycles `count` can only fall, so a push never finds the buffer full and overflow is impossible by construction.
- `VLD_OUT` / `DATA_OUT`: registered from buffer state (`VLD_OUT = count_next != 0`). The head entry drives `DATA_OUT`.
- `DATA_OUT` is don't-care while `VLD_OUT` is low, but is held stable while `VLD_OUT && !RDY_IN`.
- `PHASE_ERR_OUT`:
  - Set when `PHASE_IN` is high in this cycle and was high in the previous cycle.
  - Cleared only by reset.
  - Datapath behaviour is unchanged after it is set; each phase cycle is still treated as a slow edge.
- Reset (`RESET_N_IN` low at a clock edge):
  - `count` = 0 and buffered packets are discarded.
  - `RDY_OUT` = 0, `VLD_OUT` = 0, `PHASE_ERR_OUT` = 0, `DATA_OUT` = X.
  - The phase history flop is cleared.
  - Reset mid-operation drops any in-flight packet; there is no partial output.

## Timing
- Latency: a packet pushed at the end of phase cycle N is on `VLD_OUT`/`DATA_OUT` in cycle N+1.
- Throughput:
  - With `RDY_IN` held high, one packet is accepted per slow period (every 2 fast cycles).
  - `count` alternates 0/1 and `RDY_OUT` stays high.
- After reset release, `RDY_OUT` rises at the end of the first `PHASE_IN` cycle, so the first push is possible at the following phase cycle.
- Back-pressure:
  - With `RDY_IN` low, two packets are accepted.
  - At the phase cycle whose push makes `count_next` = 2, `RDY_OUT` falls at the end of that cycle.
  - `RDY_OUT` rises at the end of the first phase cycle where `count_next <= 1`.
- Simultaneous events:
  - With `count` = 2, a pop in a phase cycle and no push gives `count_next` = 1, and `RDY_OUT` rises at the end of that cycle.
  - With `count` = 1, a pop and a push together keep `count` at 1, and `RDY_OUT` stays high.

## Structure
- Sub-module `spio_link_speed_doubler_buf`: 2-entry register FIFO (push/pop/count/head) parameterised on `PKT_BITS`.
- Top level holds the `RDY_OUT` update and the phase-error checker.
- Shared package `spio_link_speed_pkg`: constant `SPIO_LSD_BUF_DEPTH = 2`, the count typedef, and the default `PKT_BITS = 72`. The package is shared with the halver.

## Test plan
- Reset then idle with `PHASE_IN` toggling every other cycle -> `RDY_OUT` = 0 until the end of the first phase cycle, then 1; `VLD_OUT` = 0 throughout.
- `RDY_IN` = 1, slow source sends 0x01, 0x02, 0x03 back-to-back -> each appears on `DATA_OUT` with `VLD_OUT` high for 1 cycle, the cycle after its phase cycle; `RDY_OUT` never drops.
- `RDY_IN` = 0, source sends 0xA, 0xB, 0xC -> `RDY_OUT` falls after 0xB is accepted, so 0xC is held at the source. Then `RDY_IN` = 1 -> 0xA, 0xB out on consecutive cycles, `RDY_OUT` rises at the next phase cycle, then 0xC follows.
- With `count` = 2, assert `RDY_IN` exactly in a phase cycle -> one pop, `RDY_OUT` high at the end of that cycle; no loss or duplication.
- `PHASE_IN` high for 2 consecutive cycles -> `PHASE_ERR_OUT` = 1 from the next cycle and stays set; FIFO order is preserved, with no overflow.
- Assert reset with 2 packets buffered -> next cycle `VLD_OUT` = 0, `RDY_OUT` = 0, `PHASE_ERR_OUT` = 0; the buffered packets are never output.

Source files
------------

// File: rtl/spio_link_speed_pkg.sv
// spio_link_speed_pkg: constants and types shared by the link speed halver and doubler.
package spio_link_speed_pkg;
  localparam int SPIO_LSD_BUF_DEPTH = 2;
  localparam int SPIO_LSD_PKT_BITS = 72;
  typedef logic [1:0] spio_lsd_count_t;
endpackage

// File: rtl/spio_link_speed_doubler_buf.sv
// spio_link_speed_doubler_buf: 2-entry register FIFO with head output and next-count lookahead.
module spio_link_speed_doubler_buf
  import spio_link_speed_pkg::*;
#(
  parameter int PKT_BITS = SPIO_LSD_PKT_BITS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [PKT_BITS-1:0] data_i,
  output logic [PKT_BITS-1:0] data_o,
  output spio_lsd_count_t     count_o,
  output spio_lsd_count_t     count_d_o
);
  spio_lsd_count_t count_q, count_d, cnt_ap;
  logic [PKT_BITS-1:0] e0_q, e0_d, e1_q, e1_d;
  // Pop shifts first, then the pushed packet lands in the first free slot.
  always_comb begin
    cnt_ap = count_q - spio_lsd_count_t'(pop_i);
    count_d = cnt_ap + spio_lsd_count_t'(push_i);
    e0_d = (push_i && cnt_ap == 2'd0) ? data_i : pop_i ? e1_q : e0_q;
    e1_d = (push_i && cnt_ap == 2'd1) ? data_i : e1_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) count_q <= '0;
    else count_q <= count_d;
  end
  always_ff @(posedge clk_i) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end
  assign data_o = e0_q;
  assign count_o = count_q;
  assign count_d_o = count_d;
endmodule

// File: rtl/spio_link_speed_doubler.sv
// spio_link_speed_doubler: half-rate rdy/vld source to full-rate sink, slow side seen via a phase strobe.
module spio_link_speed_doubler
  import spio_link_speed_pkg::*;
#(
  parameter int PKT_BITS = SPIO_LSD_PKT_BITS
) (
  input  logic                CLK_IN,
  input  logic                RESET_N_IN,
  input  logic                PHASE_IN,
  input  logic [PKT_BITS-1:0] DATA_IN,
  input  logic                VLD_IN,
  output logic                RDY_OUT,
  output logic [PKT_BITS-1:0] DATA_OUT,
  output logic                VLD_OUT,
  input  logic                RDY_IN,
  output logic                PHASE_ERR_OUT
);
  spio_lsd_count_t count, count_nxt;
  logic rdy_q, rdy_d, phase_q, err_q, err_d, push, pop;
  assign push = PHASE_IN && VLD_IN && rdy_q;
  assign pop = VLD_OUT && RDY_IN;
  spio_link_speed_doubler_buf #(.PKT_BITS(PKT_BITS)) u_buf (
    .clk_i(CLK_IN),
    .rst_ni(RESET_N_IN),
    .push_i(push),
    .pop_i(pop),
    .data_i(DATA_IN),
    .data_o(DATA_OUT),
    .count_o(count),
    .count_d_o(count_nxt)
  );
  // Ready only moves on slow edges, where count can no longer rise before the next one.
  always_comb begin
    rdy_d = PHASE_IN ? (count_nxt <= 2'd1) : rdy_q;
    err_d = err_q || (PHASE_IN && phase_q);
  end
  always_ff @(posedge CLK_IN) begin
    if (!RESET_N_IN) begin
      rdy_q <= 1'b0;
      phase_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rdy_q <= rdy_d;
      phase_q <= PHASE_IN;
      err_q <= err_d;
    end
  end
  assign RDY_OUT = rdy_q;
  assign VLD_OUT = count != 2'd0;
  assign PHASE_ERR_OUT = err_q;
endmodule

// File: tb/tb_spio_link_speed_doubler.sv
// tb_spio_link_speed_doubler: directed vectors with hand-computed expectations.
module tb_spio_link_speed_doubler;
  localparam int W = 72;
  logic clk = 1'b0;
  logic rst_n, phase, vld_in, rdy_out, vld_out, rdy_in, err;
  logic [W-1:0] din, dout;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  spio_link_speed_doubler #(.PKT_BITS(W)) dut (
    .CLK_IN(clk),
    .RESET_N_IN(rst_n),
    .PHASE_IN(phase),
    .DATA_IN(din),
    .VLD_IN(vld_in),
    .RDY_OUT(rdy_out),
    .DATA_OUT(dout),
    .VLD_OUT(vld_out),
    .RDY_IN(rdy_in),
    .PHASE_ERR_OUT(err)
  );
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input logic ph, input logic v, input logic [W-1:0] d, input logic r);
    phase = ph;
    vld_in = v;
    din = d;
    rdy_in = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("rst_rdy", rdy_out, 0);
    chk("rst_vld", vld_out, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick(0, 0, 0, 0);
    chk("idle_rdy_pre", rdy_out, 0);
    tick(1, 0, 0, 0);
    chk("idle_rdy_post", rdy_out, 1);
    chk("idle_vld", vld_out, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(0, 1, W'(i), 1);
      chk("stream_gap_vld", vld_out, 0);
      tick(1, 1, W'(i), 1);
      chk("stream_vld", vld_out, 1);
      chk("stream_data", dout, W'(i));
      chk("stream_rdy", rdy_out, 1);
    end
    tick(0, 0, 0, 1);
    chk("stream_drain", vld_out, 0);
    tick(0, 1, 'hA, 0);
    tick(1, 1, 'hA, 0);
    chk("bp_a_rdy", rdy_out, 1);
    chk("bp_a_data", dout, 'hA);
    tick(0, 1, 'hB, 0);
    tick(1, 1, 'hB, 0);
    chk("bp_b_rdy", rdy_out, 0);
    tick(0, 1, 'hC, 0);
    tick(1, 1, 'hC, 0);
    chk("bp_c_held_rdy", rdy_out, 0);
    chk("bp_head_a", dout, 'hA);
    tick(0, 1, 'hC, 1);
    chk("bp_out_b", dout, 'hB);
    chk("bp_out_b_vld", vld_out, 1);
    chk("bp_rdy_nonphase", rdy_out, 0);
    tick(1, 1, 'hC, 1);
    chk("bp_empty", vld_out, 0);
    chk("bp_rdy_rise", rdy_out, 1);
    tick(0, 1, 'hC, 1);
    tick(1, 1, 'hC, 1);
    chk("bp_out_c", dout, 'hC);
    chk("bp_out_c_vld", vld_out, 1);
    tick(0, 0, 0, 1);
    chk("bp_drain", vld_out, 0);
    tick(0, 1, 'h11, 0);
    tick(1, 1, 'h11, 0);
    tick(0, 1, 'h22, 0);
    tick(1, 1, 'h22, 0);
    chk("full_rdy", rdy_out, 0);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 1);
    chk("phase_pop_rdy", rdy_out, 1);
    chk("phase_pop_data", dout, 'h22);
    chk("phase_pop_vld", vld_out, 1);
    tick(0, 1, 'h33, 0);
    tick(1, 1, 'h33, 1);
    chk("pushpop_data", dout, 'h33);
    chk("pushpop_rdy", rdy_out, 1);
    tick(0, 0, 0, 1);
    chk("pushpop_drain", vld_out, 0);
    tick(1, 1, 'h44, 0);
    chk("perr_clear", err, 0);
    tick(1, 1, 'h55, 0);
    chk("perr_set", err, 1);
    chk("perr_rdy", rdy_out, 0);
    chk("perr_head", dout, 'h44);
    tick(0, 0, 0, 0);
    chk("perr_sticky", err, 1);
    tick(1, 1, 'h66, 0);
    tick(0, 0, 0, 1);
    chk("perr_second", dout, 'h55);
    tick(0, 0, 0, 1);
    chk("perr_drain", vld_out, 0);
    chk("perr_sticky2", err, 1);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(1, 1, 'h77, 0);
    tick(0, 1, 'h88, 0);
    tick(1, 1, 'h88, 0);
    chk("prerst_vld", vld_out, 1);
    chk("prerst_rdy", rdy_out, 0);
    rst_n = 1'b0;
    tick(0, 0, 0, 0);
    chk("midrst_vld", vld_out, 0);
    chk("midrst_rdy", rdy_out, 0);
    chk("midrst_err", err, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(i[0] ? 1'b0 : 1'b1, 0, 0, 1);
      chk("postrst_vld", vld_out, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
